// File: rtl/fact_accel_q.sv
// Queued factorial accelerator: bus slave with operand/result queues and an
// iterative multiply engine that drains the whole operand queue per start.
module fact_accel_q #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_din,
  output logic [DATA_W-1:0] s_dout,
  output logic              interrupt
);

  // state | meaning
  // IDLE  | waiting for OPSTART
  // LOAD  | pop next operand, seed acc/cnt
  // MUL   | acc *= cnt, cnt counts down to 2
  // WB    | push acc to result queue, stall while it is full
  // FIN   | set done, return to IDLE
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_WB, S_FIN} state_t;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = 2 * DATA_W;

  localparam logic [2:0] R_START = 3'd0, R_CLEAR = 3'd1, R_STATUS = 3'd2, R_INTR = 3'd3,
                         R_OPER  = 3'd4, R_RES_H = 3'd5, R_RES_L  = 3'd6;

  state_t state, state_nx;

  logic [DATA_W-1:0] opq_mem [DEPTH];
  logic [RW-1:0]     resq_mem [DEPTH];
  logic [PW-1:0]     opq_wr, opq_rd, resq_wr, resq_rd;
  logic [CW-1:0]     opq_cnt, resq_cnt;
  logic [RW-1:0]     acc;
  logic [DATA_W-1:0] cnt;
  logic [RW+DATA_W-1:0] prod;
  logic [DATA_W-1:0] opq_head, status;
  logic [RW-1:0]     resq_head;
  logic done, ovf, drop, intr_en;
  logic busy, opq_pop, resq_push, set_done, mul_en;

  logic       mapped, wr_en, rd_en;
  logic [2:0] rsel;
  logic wr_start, wr_clear, wr_status, wr_intr, wr_oper, rd_res_l;
  logic opq_full, opq_empty, resq_full, resq_empty, opq_push, resq_pop;

  // Only 8-byte aligned offsets inside the 64-byte window decode.
  assign rsel   = s_addr[5:3];
  assign mapped = s_sel && (s_addr[2:0] == 3'd0) && (s_addr[ADDR_W-1:6] == '0);
  assign wr_en  = mapped & s_wr;
  assign rd_en  = mapped & ~s_wr;

  assign wr_start  = wr_en && (rsel == R_START) && s_din[0];
  assign wr_clear  = wr_en && (rsel == R_CLEAR) && s_din[0];
  assign wr_status = wr_en && (rsel == R_STATUS);
  assign wr_intr   = wr_en && (rsel == R_INTR);
  assign wr_oper   = wr_en && (rsel == R_OPER);
  assign rd_res_l  = rd_en && (rsel == R_RES_L);

  assign opq_full   = (opq_cnt == CW'(DEPTH));
  assign opq_empty  = (opq_cnt == '0);
  assign resq_full  = (resq_cnt == CW'(DEPTH));
  assign resq_empty = (resq_cnt == '0);
  assign opq_push   = wr_oper & ~opq_full;
  assign resq_pop   = rd_res_l & ~resq_empty;
  assign opq_head   = opq_mem[opq_rd];
  assign resq_head  = resq_mem[resq_rd];

  assign prod = (RW+DATA_W)'(acc) * (RW+DATA_W)'(cnt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (wr_clear) state_nx = S_IDLE;
    else begin
      case (state)
        S_IDLE: if (wr_start) state_nx = opq_empty ? S_FIN : S_LOAD;
        S_LOAD: state_nx = (opq_head <= DATA_W'(1)) ? S_WB : S_MUL;
        S_MUL:  if (cnt == DATA_W'(2)) state_nx = S_WB;
        S_WB:   if (!resq_full) state_nx = (opq_empty && !opq_push) ? S_FIN : S_LOAD;
        S_FIN:  state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state != S_IDLE);
    opq_pop   = (state == S_LOAD);
    mul_en    = (state == S_MUL);
    resq_push = (state == S_WB) && !resq_full;
    set_done  = (state == S_FIN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opq_wr <= '0; opq_rd <= '0; opq_cnt <= '0;
      resq_wr <= '0; resq_rd <= '0; resq_cnt <= '0;
    end else if (wr_clear) begin
      opq_wr <= '0; opq_rd <= '0; opq_cnt <= '0;
      resq_wr <= '0; resq_rd <= '0; resq_cnt <= '0;
    end else begin
      if (opq_push)  opq_wr  <= opq_wr + 1'b1;
      if (opq_pop)   opq_rd  <= opq_rd + 1'b1;
      if (resq_push) resq_wr <= resq_wr + 1'b1;
      if (resq_pop)  resq_rd <= resq_rd + 1'b1;
      opq_cnt  <= opq_cnt + CW'(opq_push) - CW'(opq_pop);
      resq_cnt <= resq_cnt + CW'(resq_push) - CW'(resq_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (opq_push)  opq_mem[opq_wr]   <= s_din;
    if (resq_push) resq_mem[resq_wr] <= acc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (opq_pop) begin
      acc <= RW'(1);
      cnt <= opq_head;
    end else if (mul_en) begin
      acc <= prod[RW-1:0];
      cnt <= cnt - DATA_W'(1);
    end
  end

  // Flag sets win over same-cycle W1C; OPCLEAR wins over everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done <= 1'b0; ovf <= 1'b0; drop <= 1'b0; intr_en <= 1'b0;
    end else begin
      if (wr_intr) intr_en <= s_din[0];
      if (wr_clear) begin
        done <= 1'b0; ovf <= 1'b0; drop <= 1'b0;
      end else begin
        if (set_done)                    done <= 1'b1;
        else if (wr_status && s_din[0])  done <= 1'b0;
        if (mul_en && (prod[RW+DATA_W-1:RW] != '0)) ovf <= 1'b1;
        else if (wr_status && s_din[5])  ovf <= 1'b0;
        if (wr_oper && opq_full)         drop <= 1'b1;
        else if (wr_status && s_din[6])  drop <= 1'b0;
      end
    end
  end

  always_comb begin
    status        = '0;
    status[0]     = done;
    status[1]     = busy;
    status[2]     = opq_full;
    status[3]     = opq_empty;
    status[4]     = resq_empty;
    status[5]     = ovf;
    status[6]     = drop;
    status[15:8]  = 8'(opq_cnt);
    status[23:16] = 8'(resq_cnt);
  end

  always_comb begin
    s_dout = '0;
    if (rd_en) begin
      case (rsel)
        R_STATUS: s_dout = status;
        R_INTR:   s_dout[0] = intr_en;
        R_RES_H:  if (!resq_empty) s_dout = resq_head[RW-1:DATA_W];
        R_RES_L:  if (!resq_empty) s_dout = resq_head[DATA_W-1:0];
        default:  s_dout = '0;
      endcase
    end
  end

  assign interrupt = done & intr_en;

endmodule

// File: tb/tb_fact_accel_q.sv
// Directed + randomized bench for fact_accel_q; expected results come from an
// exact factorial model and queue-level bookkeeping of the register file.
module tb_fact_accel_q;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 8;

  localparam logic [7:0] A_START = 8'h00, A_CLEAR = 8'h08, A_STATUS = 8'h10, A_INTR = 8'h18,
                         A_OPER  = 8'h20, A_RES_H = 8'h28, A_RES_L  = 8'h30;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              s_sel = 1'b0;
  logic              s_wr = 1'b0;
  logic [ADDR_W-1:0] s_addr = '0;
  logic [DATA_W-1:0] s_din = '0;
  logic [DATA_W-1:0] s_dout;
  logic              interrupt;

  fact_accel_q #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr),
    .s_din(s_din), .s_dout(s_dout), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int           op_q[$];
  logic [127:0] exp_q[$];
  bit exp_done = 0, exp_ovf = 0, exp_drop = 0, exp_intr = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [63:0] d);
    @(negedge clk);
    s_sel = 1'b1; s_wr = 1'b1; s_addr = a; s_din = d;
    @(posedge clk); #1;
    s_sel = 1'b0; s_wr = 1'b0; s_din = '0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [63:0] d);
    @(negedge clk);
    s_sel = 1'b1; s_wr = 1'b0; s_addr = a;
    #1 d = s_dout;
    @(posedge clk); #1;
    s_sel = 1'b0;
  endtask

  function automatic logic [255:0] fact_exact(input int n);
    logic [255:0] p;
    p = 256'd1;
    for (int i = 2; i <= n; i++) p = p * 256'(i);
    return p;
  endfunction

  task automatic push_op(input int n);
    wr(A_OPER, 64'(n));
    if (op_q.size() < DEPTH) op_q.push_back(n);
    else exp_drop = 1;
  endtask

  task automatic model_flush();
    logic [255:0] p;
    while (op_q.size() > 0) begin
      p = fact_exact(op_q.pop_front());
      exp_q.push_back(p[127:0]);
      if (p[255:128] != '0) exp_ovf = 1;
    end
  endtask

  task automatic start_batch();
    wr(A_START, 64'd1);
    model_flush();
  endtask

  task automatic w1c(input logic [63:0] bits);
    wr(A_STATUS, bits);
    if (bits[0]) exp_done = 0;
    if (bits[5]) exp_ovf = 0;
    if (bits[6]) exp_drop = 0;
  endtask

  task automatic wait_done(input string tag);
    logic [63:0] st;
    int k;
    k = 0;
    do begin
      rd(A_STATUS, st);
      k++;
    end while (!st[0] && k < 2000);
    check({tag, "_done"}, st[0], 1'b1);
    exp_done = 1;
  endtask

  task automatic check_idle(input string tag);
    logic [63:0] st, e;
    rd(A_STATUS, st);
    e = '0;
    e[0] = exp_done;
    e[2] = (op_q.size() == DEPTH);
    e[3] = (op_q.size() == 0);
    e[4] = (exp_q.size() == 0);
    e[5] = exp_ovf;
    e[6] = exp_drop;
    e[15:8]  = 8'(op_q.size());
    e[23:16] = 8'(exp_q.size());
    check({tag, "_status"}, st, e);
    check({tag, "_irq"}, interrupt, exp_done & exp_intr);
  endtask

  task automatic pop_check(input string tag);
    logic [63:0] h, l;
    logic [127:0] e;
    rd(A_RES_H, h);
    rd(A_RES_L, l);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'd0;
    check({tag, "_h"}, h, e[127:64]);
    check({tag, "_l"}, l, e[63:0]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] st;
    int k, n, nb;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    check("reset_dout", s_dout, 64'd0);
    check("reset_irq", interrupt, 1'b0);
    check_idle("reset");

    // single operand 5: count busy cycles
    push_op(5);
    start_batch();
    nb = 0;
    k = 0;
    do begin
      rd(A_STATUS, st);
      if (st[1]) nb++;
      k++;
    end while (st[1] && k < 100);
    check("busy_cycles_5", 128'(nb), 128'd7);
    exp_done = 1;
    check_idle("after_5");
    pop_check("fact5");
    check_idle("after_5_pop");
    w1c(64'h1);

    // start with empty operand queue
    start_batch();
    wait_done("empty_start");
    check_idle("empty_start");
    w1c(64'h1);

    // interrupt path
    wr(A_INTR, 64'd1);
    exp_intr = 1;
    rd(A_INTR, st);
    check("intr_en_rd", st, 64'd1);
    push_op(0); push_op(1); push_op(20); push_op(21);
    start_batch();
    check("irq_low_busy", interrupt, 1'b0);
    k = 0;
    while (!interrupt && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("irq_rise", interrupt, 1'b1);
    exp_done = 1;
    pop_check("f0"); pop_check("f1"); pop_check("f20"); pop_check("f21");
    w1c(64'h1);
    check("irq_cleared", interrupt, 1'b0);

    // overfill operand queue
    for (int i = 0; i <= DEPTH; i++) push_op(int'($urandom_range(0, 12)));
    check_idle("opq_full");
    start_batch();
    wait_done("full_batch");
    check_idle("full_batch");
    for (int i = 0; i < DEPTH; i++) pop_check("full_pop");
    check_idle("full_drained");
    w1c(64'h41);

    // overflow
    push_op(35);
    start_batch();
    wait_done("ovf35");
    check_idle("ovf35");
    pop_check("f35");
    w1c(64'h21);
    check_idle("ovf_cleared");

    // result queue full: engine stalls in WB
    for (int i = 0; i < DEPTH; i++) push_op(int'($urandom_range(0, 12)));
    start_batch();
    wait_done("fill_resq");
    check_idle("resq_full");
    w1c(64'h1);
    push_op(int'($urandom_range(2, 12)));
    start_batch();
    repeat (30) @(negedge clk);
    rd(A_STATUS, st);
    check("stall_busy", st[1], 1'b1);
    check("stall_done", st[0], 1'b0);
    check("stall_resq_cnt", st[23:16], 8'(DEPTH));
    pop_check("stall_pop");
    rd(A_STATUS, st);
    check("stall_after_pop_cnt", st[23:16], 8'(DEPTH - 1));
    check("stall_after_pop_busy", st[1], 1'b1);
    wait_done("stall_release");
    check_idle("stall_release");
    for (int i = 0; i < DEPTH; i++) pop_check("stall_drain");
    w1c(64'h1);

    // operand pushed while the batch is running
    push_op(25);
    start_batch();
    push_op(4);
    model_flush();
    wait_done("midbatch");
    check_idle("midbatch");
    pop_check("f25"); pop_check("f4_late");
    w1c(64'h21);

    // random batches
    for (int b = 0; b < 4; b++) begin
      n = int'($urandom_range(1, DEPTH));
      for (int i = 0; i < n; i++) push_op(int'($urandom_range(0, 40)));
      start_batch();
      wait_done("rand_batch");
      check_idle("rand_batch");
      while (exp_q.size() > 0) pop_check("rand_pop");
      w1c(64'h61);
      check_idle("rand_cleared");
    end

    // OPCLEAR during MUL flushes everything except intr_en
    push_op(2);
    start_batch();
    wait_done("pre_clear");
    push_op(30);
    start_batch();
    repeat (5) @(negedge clk);
    push_op(7);
    wr(A_CLEAR, 64'd1);
    op_q.delete();
    exp_q.delete();
    exp_done = 0; exp_ovf = 0; exp_drop = 0;
    check_idle("after_clear");
    rd(A_INTR, st);
    check("intr_en_kept", st, 64'd1);
    push_op(3);
    start_batch();
    wait_done("post_clear");
    check_idle("post_clear");
    pop_check("f3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
